// File: rtl/multigate_deser8_pkg.sv
// Shared types and defaults for the multigate_deser8 deserializer.
package multigate_deser8_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/multigate_deser8_if.sv
// Serial input and parallel output handshake bundle.
interface multigate_deser8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             ser_in;
    logic             ser_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bus;
    logic             bus_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, ser_in, ser_valid, out_ready,
        input  bus, bus_valid, busy, overrun
    );

    modport slave (
        input  start, ser_in, ser_valid, out_ready,
        output bus, bus_valid, busy, overrun
    );
endinterface

// File: rtl/multigate_deser8_bitcnt.sv
// Bit position counter; flags the final bit slot of a word.
module multigate_deser8_bitcnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);
    logic [CNT_W-1:0] r_count;

    // a restart beat wins over completion and increment
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= CNT_W'(1);
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/multigate_deser8.sv
// LSB-first serial-to-parallel deserializer with one registered
// output word and a sticky overrun flag.
module multigate_deser8
    import multigate_deser8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic               i_clk,
    input logic               i_reset,
    multigate_deser8_if.slave s
);
    if (WIDTH < 2 || WIDTH > 16 || (1 << CNT_W) < WIDTH) begin : g_bad_param
        $error("multigate_deser8: bad WIDTH/CNT_W");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_bus;
    logic             r_bus_valid;
    logic             r_busy;
    logic             r_overrun;

    logic             w_beat;
    logic             w_restart;
    logic             w_done;
    logic             w_inc;
    logic             w_last;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_idx;
    logic [WIDTH-1:0] w_word;

    assign w_beat    = s.ser_valid & (s.start | (r_state == ST_SHIFT));
    assign w_restart = w_beat & s.start;
    assign w_done    = w_beat & ~s.start & w_last;
    assign w_inc     = w_beat & ~s.start & ~w_last;
    assign w_idx     = s.start ? '0 : w_count;
    assign w_word    = {s.ser_in, r_shift[WIDTH-2:0]};

    multigate_deser8_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_done),
        .i_load1 (w_restart),
        .i_inc   (w_inc),
        .o_count (w_count),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bus       <= '0;
            r_bus_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_restart) begin
                r_state <= ST_SHIFT;
            end else if (w_done) begin
                r_state <= ST_IDLE;
            end
            r_busy <= w_restart | ((r_state == ST_SHIFT) & ~w_done);

            for (int i = 0; i < WIDTH; i++) begin
                if (w_beat && w_idx == CNT_W'(i)) begin
                    r_shift[i] <= s.ser_in;
                end
            end

            // one word of buffering: a full, unread bus drops the new word
            if (w_done) begin
                if (!r_bus_valid || s.out_ready) begin
                    r_bus       <= w_word;
                    r_bus_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_bus_valid && s.out_ready) begin
                r_bus_valid <= 1'b0;
            end
        end
    end

    assign s.bus       = r_bus;
    assign s.bus_valid = r_bus_valid;
    assign s.busy      = r_busy;
    assign s.overrun   = r_overrun;
endmodule

// File: tb/tb_multigate_deser8.sv
// Bench for multigate_deser8: directed cases plus random traffic
// compared every cycle against a word-level behavioural model.
module tb_multigate_deser8;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multigate_deser8_if #(.WIDTH(W)) bus_if ();

    multigate_deser8 #(.WIDTH(W), .CNT_W(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .s       (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // behavioural model: bits gathered so far, pending word, flags
    int         m_n = 0;
    int         m_acc = 0;
    logic [7:0] m_bus = '0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit done;
        int word;
        done = 1'b0;
        word = 0;
        if (reset) begin
            m_n = 0; m_acc = 0; m_bus = '0;
            m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            if (bus_if.ser_valid && bus_if.start) begin
                m_acc = int'(bus_if.ser_in);
                m_n = 1;
            end else if (bus_if.ser_valid && m_n > 0) begin
                m_acc = m_acc + (int'(bus_if.ser_in) << m_n);
                m_n++;
                if (m_n == W) begin
                    done = 1'b1;
                    word = m_acc;
                    m_n = 0;
                end
            end
            if (done) begin
                if (!m_valid || bus_if.out_ready) begin
                    m_bus = word[7:0];
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && bus_if.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_bus", 32'(bus_if.bus), 32'(m_bus));
            chk("model_bus_valid", 32'(bus_if.bus_valid), 32'(m_valid));
            chk("model_busy", 32'(bus_if.busy), 32'(m_n > 0));
            chk("model_overrun", 32'(bus_if.overrun), 32'(m_ovr));
        end
    end

    task automatic idle_inputs();
        bus_if.start = 1'b0;
        bus_if.ser_in = 1'b0;
        bus_if.ser_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus_if.out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap,
                             input bit rdy_last);
        for (int i = 0; i < W; i++) begin
            bus_if.start = (i == 0);
            bus_if.ser_in = w[i];
            bus_if.ser_valid = 1'b1;
            if (rdy_last) bus_if.out_ready = (i == W - 1);
            @(negedge clk);
            idle_inputs();
            if (rdy_last) bus_if.out_ready = 1'b0;
            if (i < W - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_partial(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus_if.start = (i == 0);
            bus_if.ser_in = w[i];
            bus_if.ser_valid = 1'b1;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_bus", 32'(bus_if.bus), 32'h0);
        chk("reset_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("reset_busy", 32'(bus_if.busy), 32'h0);
        reset = 1'b0;

        // 1: bits 1,0,1,1,0,0,1,0 -> 4D
        send_word(8'h4D, 0, 1'b0);
        chk("t1_bus", 32'(bus_if.bus), 32'h4D);
        chk("t1_valid", 32'(bus_if.bus_valid), 32'h1);
        chk("t1_busy", 32'(bus_if.busy), 32'h0);

        // 2: overrun while A5 is held
        do_reset();
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h3C, 0, 1'b0);
        chk("t2_bus", 32'(bus_if.bus), 32'hA5);
        chk("t2_ovr", 32'(bus_if.overrun), 32'h1);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        chk("t2_drain", 32'(bus_if.bus_valid), 32'h0);
        chk("t2_ovr_sticky", 32'(bus_if.overrun), 32'h1);

        // 3: transfer and completion on the same cycle
        do_reset();
        send_word(8'h11, 0, 1'b0);
        send_word(8'hFF, 0, 1'b1);
        chk("t3_bus", 32'(bus_if.bus), 32'hFF);
        chk("t3_valid", 32'(bus_if.bus_valid), 32'h1);
        chk("t3_ovr", 32'(bus_if.overrun), 32'h0);

        // 4: gaps of 3 idle cycles between beats
        do_reset();
        send_word(8'hC6, 3, 1'b0);
        chk("t4_bus", 32'(bus_if.bus), 32'hC6);
        chk("t4_valid", 32'(bus_if.bus_valid), 32'h1);

        // 5: restart at beat 5 discards the partial word
        do_reset();
        send_partial(8'hFF, 5);
        send_word(8'h96, 0, 1'b0);
        chk("t5_bus", 32'(bus_if.bus), 32'h96);
        chk("t5_ovr", 32'(bus_if.overrun), 32'h0);

        // 6: reset mid-word and with a word pending
        send_partial(8'hF0, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6a_bus", 32'(bus_if.bus), 32'h0);
        chk("t6a_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("t6a_busy", 32'(bus_if.busy), 32'h0);
        send_word(8'h5A, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6b_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("t6b_bus", 32'(bus_if.bus), 32'h0);
        send_word(8'h3E, 0, 1'b0);
        chk("t6c_bus", 32'(bus_if.bus), 32'h3E);

        // random traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus_if.start = ($urandom_range(0, 11) == 0);
            bus_if.ser_valid = ($urandom_range(0, 9) < 7);
            bus_if.ser_in = 1'($urandom);
            bus_if.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
